// File: rtl/trivium_pkg.sv
// trivium_pkg: shared FSM type, Trivium tap positions and the seed-to-state load mapping
package trivium_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, INIT, GEN} fsm_t;
    localparam int STATE_W = 288;
    localparam int KEY_W = 80;
    localparam int IV_W = 80;
    localparam int T1A = 66;
    localparam int T1B = 93;
    localparam int T2A = 162;
    localparam int T2B = 177;
    localparam int T3A = 243;
    localparam int T3B = 288;
    localparam int T1C = 91;
    localparam int T1D = 92;
    localparam int T1E = 171;
    localparam int T2C = 175;
    localparam int T2D = 176;
    localparam int T2E = 264;
    localparam int T3C = 286;
    localparam int T3D = 287;
    localparam int T3E = 69;
    // s(i) lives in bit i-1: key in s1..s80, iv in s94..s173, ones in s286..s288
    function automatic logic [STATE_W-1:0] load_state(input logic [7:0] seed, input logic [7:0] iv_xor);
        logic [KEY_W-1:0] key;
        logic [IV_W-1:0] iv;
        key = {10{seed}};
        iv = {10{seed ^ iv_xor}};
        return {3'b111, 108'b0, 4'b0, iv, 13'b0, key};
    endfunction
endpackage

// File: rtl/trivium_core.sv
// trivium_core: one combinational Trivium round producing the next state and keystream bit
module trivium_core
    import trivium_pkg::*;
(
    input  logic [STATE_W-1:0] st,
    output logic [STATE_W-1:0] st_next,
    output logic               z
);
    logic t1, t2, t3;
    // output bit from the linear taps, then feedback and a one-position shift of all three registers
    always_comb begin
        t1 = st[T1A-1] ^ st[T1B-1];
        t2 = st[T2A-1] ^ st[T2B-1];
        t3 = st[T3A-1] ^ st[T3B-1];
        z = t1 ^ t2 ^ t3;
        st_next = {st[286:177], t2 ^ (st[T2C-1] & st[T2D-1]) ^ st[T2E-1],
                   st[175:93],  t1 ^ (st[T1C-1] & st[T1D-1]) ^ st[T1E-1],
                   st[91:0],    t3 ^ (st[T3C-1] & st[T3D-1]) ^ st[T3E-1]};
    end
endmodule

// File: rtl/trivium_keystream_gen.sv
// trivium_keystream_gen: seeds Trivium, runs warm-up, then streams packed keystream bytes over valid/ready
module trivium_keystream_gen
    import trivium_pkg::*;
#(
    parameter int         WARMUP_CYCLES = 1152,
    parameter logic [7:0] IV_XOR        = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seed_valid,
    input  logic [7:0] seed,
    input  logic       clear,
    input  logic       ks_ready,
    output logic       ks_valid,
    output logic [7:0] ks_byte,
    output logic       busy
);
    localparam int CW = $clog2(WARMUP_CYCLES + 1);
    fsm_t state, next_state;
    logic [STATE_W-1:0] st, st_next;
    logic z, advance, complete, warm_done;
    logic [CW-1:0] warm_cnt;
    logic [2:0] bit_cnt;
    logic [6:0] pack;
    logic [7:0] seed_q;
    trivium_core u_core (.st(st), .st_next(st_next), .z(z));
    // the 8th bit may not complete while an unaccepted byte is still held
    assign advance = (state == GEN) && !(bit_cnt == 3'd7 && ks_valid && !ks_ready);
    assign complete = advance && bit_cnt == 3'd7;
    assign warm_done = warm_cnt == CW'(WARMUP_CYCLES - 1);
    assign busy = state == LOAD || state == INIT;
    // FSM state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= next_state;
    // next state: clear beats seed_valid, which restarts from any state
    always_comb begin
        next_state = clear ? IDLE :
                     seed_valid ? LOAD :
                     state == LOAD ? INIT :
                     (state == INIT && warm_done) ? GEN : state;
    end
    // cipher state, counters, byte packer and output handshake
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            st <= '0;
            warm_cnt <= '0;
            bit_cnt <= '0;
            pack <= '0;
            seed_q <= '0;
            ks_valid <= 1'b0;
            ks_byte <= '0;
        end else if (clear) begin
            st <= '0;
            warm_cnt <= '0;
            bit_cnt <= '0;
            pack <= '0;
            ks_valid <= 1'b0;
            ks_byte <= '0;
        end else if (seed_valid) begin
            seed_q <= seed;
            ks_valid <= 1'b0;
        end else begin
            if (state == LOAD) begin
                st <= load_state(seed_q, IV_XOR);
                warm_cnt <= '0;
                bit_cnt <= '0;
                pack <= '0;
            end else if (state == INIT) begin
                st <= st_next;
                warm_cnt <= warm_cnt + 1'b1;
            end else if (advance) begin
                st <= st_next;
                bit_cnt <= bit_cnt + 1'b1;
                pack <= {pack[5:0], z};
            end
            if (complete) ks_byte <= {pack, z};
            ks_valid <= complete | (ks_valid & ~ks_ready);
        end
endmodule

// File: tb/tb_trivium_keystream_gen.sv
// tb_trivium_keystream_gen: randomized checks of the keystream generator against a bit-array Trivium model
module tb_trivium_keystream_gen;
    localparam int W = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic seed_valid = 1'b0;
    logic clear = 1'b0;
    logic ks_ready = 1'b0;
    logic [7:0] seed = 8'h00;
    logic ks_valid, busy;
    logic [7:0] ks_byte;
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] k1[4];
    logic [7:0] k2[4];
    logic [7:0] pats[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0] hold;
    always #5 clk = ~clk;
    trivium_keystream_gen #(.WARMUP_CYCLES(W), .IV_XOR(8'hA5)) dut (
        .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed), .clear(clear),
        .ks_ready(ks_ready), .ks_valid(ks_valid), .ks_byte(ks_byte), .busy(busy)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask
    // Trivium written directly on s[1..288], producing the no-stall byte sequence for a seed
    task automatic model_load(input logic [7:0] sd, input int n);
        bit s[1:288];
        bit t1, t2, t3, z;
        logic [7:0] ivb, b;
        exp_q.delete();
        got_q.delete();
        s = '{default: 1'b0};
        ivb = sd ^ 8'hA5;
        b = 8'h00;
        for (int i = 1; i <= 80; i++) begin
            s[i] = sd[(i - 1) % 8];
            s[93 + i] = ivb[(i - 1) % 8];
        end
        s[286] = 1'b1;
        s[287] = 1'b1;
        s[288] = 1'b1;
        for (int k = 0; k < W + 8 * n; k++) begin
            t1 = s[66] ^ s[93];
            t2 = s[162] ^ s[177];
            t3 = s[243] ^ s[288];
            z = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[91] & s[92]) ^ s[171];
            t2 = t2 ^ (s[175] & s[176]) ^ s[264];
            t3 = t3 ^ (s[286] & s[287]) ^ s[69];
            for (int i = 93; i > 1; i--) s[i] = s[i - 1];
            s[1] = t3;
            for (int i = 177; i > 94; i--) s[i] = s[i - 1];
            s[94] = t1;
            for (int i = 288; i > 178; i--) s[i] = s[i - 1];
            s[178] = t2;
            if (k >= W) begin
                b = {b[6:0], z};
                if ((k - W) % 8 == 7) exp_q.push_back(b);
            end
        end
    endtask
    // score a transfer happening at the coming edge, then move to the next falling edge
    task automatic tick();
        if (ks_valid && ks_ready) begin
            got_q.push_back(ks_byte);
            if (exp_q.size() == 0) check("extra_byte", 1, 0);
            else check("ks_byte", ks_byte, exp_q.pop_front());
        end
        @(negedge clk);
    endtask
    task automatic pulse_seed(input logic [7:0] sd);
        ks_ready = 1'b0;
        seed = sd;
        seed_valid = 1'b1;
        model_load(sd, 64);
        tick();
        seed_valid = 1'b0;
        ks_ready = 1'b1;
    endtask
    task automatic measure(input string tag, input int ncyc);
        int first, last, nb;
        first = -1;
        last = 0;
        nb = 0;
        for (int k = 0; k < ncyc; k++) begin
            if (busy) nb++;
            if (ks_valid) begin
                if (first < 0) first = k;
                else check({tag, "_interval"}, k - last, 8);
                last = k;
            end
            tick();
        end
        check({tag, "_first_valid"}, first, 25);
        check({tag, "_busy_cycles"}, nb, 17);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tick();
        check("rst_valid", ks_valid, 0);
        check("rst_byte", ks_byte, 0);
        check("rst_busy", busy, 0);
        repeat (5) tick();
        check("idle_valid", ks_valid, 0);
        check("idle_busy", busy, 0);
        pulse_seed(8'h76);
        measure("lat", 60);
        check("lat_count", got_q.size(), 5);
        for (int i = 0; i < 4; i++) k1[i] = got_q[i];
        ks_ready = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_valid", ks_valid, 0);
        check("clr_busy", busy, 0);
        pulse_seed(8'h76);
        measure("lat2", 60);
        check("lat2_count", got_q.size(), 5);
        for (int i = 0; i < 4; i++) begin
            k2[i] = got_q[i];
            check("repro", k2[i], k1[i]);
            check("round_trip", (pats[i] ^ k2[i]) ^ k1[i], pats[i]);
        end
        pulse_seed(8'($urandom));
        for (int k = 0; k < 40 && !ks_valid; k++) tick();
        check("bp_reach", ks_valid, 1);
        ks_ready = 1'b0;
        hold = ks_byte;
        for (int k = 0; k < 30; k++) begin
            tick();
            check("bp_valid", ks_valid, 1);
            check("bp_hold", ks_byte, hold);
        end
        ks_ready = 1'b1;
        tick();
        check("bp_sim_valid", ks_valid, 1);
        repeat (63) tick();
        check("bp_count", got_q.size(), 9);
        pulse_seed(8'($urandom));
        for (int k = 0; k < 400; k++) begin
            ks_ready = 1'($urandom % 2);
            tick();
        end
        check("rnd_some_bytes", got_q.size() >= 10, 1);
        ks_ready = 1'b1;
        clear = 1'b1;
        seed_valid = 1'b1;
        seed = 8'h11;
        tick();
        clear = 1'b0;
        seed_valid = 1'b0;
        exp_q.delete();
        check("prio_valid", ks_valid, 0);
        check("prio_busy", busy, 0);
        repeat (30) tick();
        check("prio_idle_valid", ks_valid, 0);
        check("prio_idle_busy", busy, 0);
        pulse_seed(8'h3C);
        for (int k = 0; k < 8; k++) begin
            check("rs_busy", busy, 1);
            tick();
        end
        pulse_seed(8'hC3);
        measure("rs", 60);
        check("rs_count", got_q.size(), 5);
        ks_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        exp_q.delete();
        tick();
        check("rst2_valid", ks_valid, 0);
        check("rst2_byte", ks_byte, 0);
        check("rst2_busy", busy, 0);
        ks_ready = 1'b1;
        repeat (40) tick();
        check("rst2_idle_valid", ks_valid, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
